move_sequencer: RTL

- Sequences both wheel step controllers (one stepctl per wheel) through a short stored motion program: forward, reverse, pivot-left, pivot-right and timed waits.
- For each move it sets direction bits and a shared encoder-tick target, issues a one-cycle go pulse, waits for both wheels to finish, then pauses before the next move.
- It sits between the top-level button/edge detector and the two stepctl instances, replacing the direct button-to-enable connection.

---
 rtl/move_sequencer_pkg.sv | 26 ++
 rtl/move_sequencer_if.sv | 44 ++++
 rtl/move_prog_mem.sv | 27 ++
 rtl/move_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/move_sequencer_pkg.sv
// Shared definitions for the wheel move sequencer:
// opcodes, FSM state encoding and program word width.
package move_sequencer_pkg;

    localparam int PROG_W = 19;

    localparam logic [2:0] OP_END  = 3'd0;
    localparam logic [2:0] OP_FWD  = 3'd1;
    localparam logic [2:0] OP_REV  = 3'd2;
    localparam logic [2:0] OP_PIVL = 3'd3;
    localparam logic [2:0] OP_PIVR = 3'd4;
    localparam logic [2:0] OP_WAIT = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_ARM,
        S_RUN,
        S_WAITING,
        S_NEXT,
        S_DONE,
        S_ABORT
    } state_t;

endpackage

// File: rtl/move_sequencer_if.sv
// Control/status bundle between the button logic, the
// sequencer (slave side) and both stepctl instances.
// Inputs: start, abort, prog_we/addr/data, motorL/R_busy.
// Outputs: step_go, step_target, motorL/R_dir, halt,
// seq_busy, seq_done, pc.
interface move_sequencer_if
    import move_sequencer_pkg::*;
#(
    parameter int AW = 4
);
    logic              start;
    logic              abort;
    logic              prog_we;
    logic [AW-1:0]     prog_addr;
    logic [PROG_W-1:0] prog_data;
    logic              motorL_busy;
    logic              motorR_busy;
    logic              step_go;
    logic [15:0]       step_target;
    logic              motorL_dir;
    logic              motorR_dir;
    logic              halt;
    logic              seq_busy;
    logic              seq_done;
    logic [AW-1:0]     pc;

    modport slave (
        input  start, abort,
        input  prog_we, prog_addr, prog_data,
        input  motorL_busy, motorR_busy,
        output step_go, step_target,
        output motorL_dir, motorR_dir,
        output halt, seq_busy, seq_done, pc
    );

    modport master (
        output start, abort,
        output prog_we, prog_addr, prog_data,
        output motorL_busy, motorR_busy,
        input  step_go, step_target,
        input  motorL_dir, motorR_dir,
        input  halt, seq_busy, seq_done, pc
    );
endinterface

// File: rtl/move_prog_mem.sv
// Motion program store: DEPTH x W words, synchronous
// write, combinational read (maps onto LUT RAM).
// Ports: clk, we/waddr/wdata write side, raddr/rdata read.
module move_prog_mem
    import move_sequencer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = PROG_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/move_sequencer.sv
// Runs a stored motion program on both wheel stepctls.
// Ports: WF_CLK, rst (async, active-high), bus (slave).
module move_sequencer
    import move_sequencer_pkg::*;
#(
    parameter int          DEPTH       = 16,
    parameter logic [23:0] PAUSE_CYC   = 24'd1200000,
    parameter logic [15:0] WAIT_TICK   = 16'd12000,
    parameter logic [7:0]  ARM_TIMEOUT = 8'd64
) (
    input  logic            WF_CLK,
    input  logic            rst,
    move_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [31:0]       timer_q, timer_d;
    logic [23:0]       pause_q, pause_d;
    logic [7:0]        arm_q, arm_d;
    logic [15:0]       target_q, target_d;
    logic              dir_l_q, dir_l_d;
    logic              dir_r_q, dir_r_d;
    logic [PROG_W-1:0] entry;
    logic [2:0]        op;
    logic [15:0]       cnt;
    logic              mem_we;
    logic              any_busy;

    // Memory is only writable while no program runs.
    assign mem_we = bus.prog_we && (state_q == S_IDLE);

    move_prog_mem #(
        .DEPTH (DEPTH),
        .W     (PROG_W)
    ) u_mem (
        .clk   (WF_CLK),
        .we    (mem_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (pc_q),
        .rdata (entry)
    );

    assign op       = entry[18:16];
    assign cnt      = entry[15:0];
    assign any_busy = bus.motorL_busy || bus.motorR_busy;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        timer_d  = timer_q;
        pause_d  = pause_q;
        arm_d    = arm_q;
        target_d = target_q;
        dir_l_d  = dir_l_q;
        dir_r_d  = dir_r_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                case (op)
                    OP_FWD, OP_REV, OP_PIVL, OP_PIVR: begin
                        dir_l_d  = (op == OP_REV) || (op == OP_PIVL);
                        dir_r_d  = (op == OP_REV) || (op == OP_PIVR);
                        target_d = cnt;
                        state_d  = (cnt == '0) ? S_NEXT : S_ISSUE;
                    end
                    OP_WAIT: begin
                        timer_d = 32'(cnt) * 32'(WAIT_TICK);
                        state_d = (cnt == '0) ? S_NEXT : S_WAITING;
                    end
                    default: state_d = S_DONE;
                endcase
            end
            S_ISSUE: begin
                arm_d   = '0;
                state_d = S_ARM;
            end
            S_ARM: begin
                // A wheel that never starts must not stall the program.
                if (any_busy) begin
                    state_d = S_RUN;
                end else if (arm_q == ARM_TIMEOUT - 8'd1) begin
                    state_d = S_NEXT;
                end else begin
                    arm_d = arm_q + 8'd1;
                end
            end
            S_RUN: begin
                if (!any_busy) begin
                    state_d = S_NEXT;
                end
            end
            S_WAITING: begin
                timer_d = timer_q - 32'd1;
                if (timer_q <= 32'd1) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (pause_q == '0) begin
                    if (pc_q == PC_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    pause_d = pause_q - 24'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: begin
                if (!any_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pause length is armed on every entry into NEXT.
        if (state_d == S_NEXT && state_q != S_NEXT) begin
            pause_d = PAUSE_CYC;
        end

        // Abort freezes all bookkeeping and wins over every state.
        if (bus.abort && state_q != S_IDLE && state_q != S_ABORT) begin
            pc_d     = pc_q;
            timer_d  = timer_q;
            pause_d  = pause_q;
            arm_d    = arm_q;
            target_d = target_q;
            dir_l_d  = dir_l_q;
            dir_r_d  = dir_r_q;
            state_d  = S_ABORT;
        end
    end

    always_ff @(posedge WF_CLK or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            timer_q  <= '0;
            pause_q  <= '0;
            arm_q    <= '0;
            target_q <= '0;
            dir_l_q  <= 1'b0;
            dir_r_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            timer_q  <= timer_d;
            pause_q  <= pause_d;
            arm_q    <= arm_d;
            target_q <= target_d;
            dir_l_q  <= dir_l_d;
            dir_r_q  <= dir_r_d;
        end
    end

    assign bus.step_go     = (state_q == S_ISSUE) && !bus.abort;
    assign bus.seq_done    = (state_q == S_DONE) && !bus.abort;
    assign bus.halt        = (state_q == S_ABORT);
    assign bus.seq_busy    = (state_q != S_IDLE);
    assign bus.pc          = pc_q;
    assign bus.step_target = target_q;
    assign bus.motorL_dir  = dir_l_q;
    assign bus.motorR_dir  = dir_r_q;
endmodule
